// File: rtl/striping_pkg.sv
// Shared constants and lane-select state encoding for the two-lane striping block.
package striping_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NEXT_L1 = 2'd1,
    NEXT_L0 = 2'd2
  } lane_state_e;

endpackage

// File: rtl/striping_lane.sv
// One output lane: captures a word on load and holds it for two clk_2f cycles,
// then drops valid and zeroes the data unless a fresh word replaces it.
module striping_lane
  import striping_pkg::*;
(
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] lane,
  output logic              valid
);

  logic hold;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      lane  <= '0;
      valid <= 1'b0;
      hold  <= 1'b0;
    end else if (load) begin
      lane  <= din;
      valid <= 1'b1;
      hold  <= 1'b0;
    end else if (valid) begin
      if (hold) begin
        lane  <= '0;
        valid <= 1'b0;
        hold  <= 1'b0;
      end else begin
        hold <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/striping.sv
// Splits an incoming word stream alternately across two half-rate lanes,
// realigning to lane 0 after a gap of two or more idle cycles.
module striping
  import striping_pkg::*;
(
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic              valid_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_1
);

  lane_state_e state, state_nxt;
  logic        gap_cnt, gap_nxt;
  logic        load_0, load_1;

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gap_cnt <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    load_0    = 1'b0;
    load_1    = 1'b0;
    if (valid_in) begin
      gap_nxt = 1'b0;
      if (state == NEXT_L1) begin
        load_1    = 1'b1;
        state_nxt = NEXT_L0;
      end else begin
        load_0    = 1'b1;
        state_nxt = NEXT_L1;
      end
    end else if (gap_cnt) begin
      // Second consecutive idle cycle marks a burst boundary.
      state_nxt = IDLE;
    end else begin
      gap_nxt = 1'b1;
    end
  end

  striping_lane u_lane_0 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .load   (load_0),
    .din    (data_in),
    .lane   (lane_0),
    .valid  (valid_0)
  );

  striping_lane u_lane_1 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .load   (load_1),
    .din    (data_in),
    .lane   (lane_1),
    .valid  (valid_1)
  );

endmodule

// File: tb/tb_striping.sv
// Directed self-checking bench for striping: table of per-cycle vectors plus
// hand-written reset sequences.
module tb_striping;

  logic        clk_2f;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic [31:0] lane_0, lane_1;
  logic        valid_0, valid_1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] d;
    logic        ev0;
    logic [31:0] el0;
    logic        ev1;
    logic [31:0] el1;
  } vec_t;

  vec_t vq[$];

  striping dut (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .lane_0   (lane_0),
    .valid_0  (valid_0),
    .lane_1   (lane_1),
    .valid_1  (valid_1)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic check(input string name, input logic ev0, input logic [31:0] el0,
                       input logic ev1, input logic [31:0] el1);
    checks++;
    if ({valid_0, lane_0, valid_1, lane_1} !== {ev0, el0, ev1, el1}) begin
      errors++;
      $display("FAIL %s: got v0=%b l0=%h v1=%b l1=%h, expected v0=%b l0=%h v1=%b l1=%h",
               name, valid_0, lane_0, valid_1, lane_1, ev0, el0, ev1, el1);
    end
  endtask

  function automatic void add(input string n, input logic v, input logic [31:0] d,
                              input logic ev0, input logic [31:0] el0,
                              input logic ev1, input logic [31:0] el1);
    vec_t t;
    t.name = n; t.v = v; t.d = d;
    t.ev0 = ev0; t.el0 = el0; t.ev1 = ev1; t.el1 = el1;
    vq.push_back(t);
  endfunction

  initial begin
    // Stream: A1,B2,C3,D4 then idle
    add("stream_a1", 1, 32'hA1, 1, 32'hA1, 0, 32'h0);
    add("stream_b2", 1, 32'hB2, 1, 32'hA1, 1, 32'hB2);
    add("stream_c3", 1, 32'hC3, 1, 32'hC3, 1, 32'hB2);
    add("stream_d4", 1, 32'hD4, 1, 32'hC3, 1, 32'hD4);
    add("stream_i1", 0, 32'h0,  0, 32'h0,  1, 32'hD4);
    add("stream_i2", 0, 32'h0,  0, 32'h0,  0, 32'h0);
    add("stream_i3", 0, 32'h0,  0, 32'h0,  0, 32'h0);
    // Single gap keeps alternation
    add("gap1_w11",  1, 32'h11, 1, 32'h11, 0, 32'h0);
    add("gap1_idle", 0, 32'h0,  1, 32'h11, 0, 32'h0);
    add("gap1_w22",  1, 32'h22, 0, 32'h0,  1, 32'h22);
    add("gap1_i1",   0, 32'h0,  0, 32'h0,  1, 32'h22);
    add("gap1_i2",   0, 32'h0,  0, 32'h0,  0, 32'h0);
    // Two-cycle gap realigns to lane 0
    add("gap2_w11",  1, 32'h11, 1, 32'h11, 0, 32'h0);
    add("gap2_i1",   0, 32'h0,  1, 32'h11, 0, 32'h0);
    add("gap2_i2",   0, 32'h0,  0, 32'h0,  0, 32'h0);
    add("gap2_w22",  1, 32'h22, 1, 32'h22, 0, 32'h0);
    add("gap2_i3",   0, 32'h0,  1, 32'h22, 0, 32'h0);
    add("gap2_i4",   0, 32'h0,  0, 32'h0,  0, 32'h0);
    // Hold: single all-ones word lasts exactly two cycles
    add("hold_w",    1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 32'h0);
    add("hold_c2",   0, 32'h0,        1, 32'hFFFFFFFF, 0, 32'h0);
    add("hold_exp",  0, 32'h0,        0, 32'h0,        0, 32'h0);

    reset = 1'b0; valid_in = 1'b1; data_in = 32'hDEADBEEF;
    @(posedge clk_2f); @(negedge clk_2f);
    check("reset_hold", 0, 32'h0, 0, 32'h0);
    @(posedge clk_2f); @(negedge clk_2f);
    check("reset_hold2", 0, 32'h0, 0, 32'h0);

    // Release with no word, run the vector table
    valid_in = 1'b0; data_in = '0;
    reset = 1'b1;
    foreach (vq[i]) begin
      valid_in = vq[i].v;
      data_in  = vq[i].d;
      @(posedge clk_2f); @(negedge clk_2f);
      check(vq[i].name, vq[i].ev0, vq[i].el0, vq[i].ev1, vq[i].el1);
    end

    // Reset mid-burst: words 1,2 accepted, reset before word 3
    valid_in = 1'b1; data_in = 32'h1;
    @(posedge clk_2f); @(negedge clk_2f);
    data_in = 32'h2;
    @(posedge clk_2f); @(negedge clk_2f);
    check("midrst_pre", 1, 32'h1, 1, 32'h2);
    #1 reset = 1'b0; valid_in = 1'b0; data_in = '0;
    #1 check("midrst_async_clear", 0, 32'h0, 0, 32'h0);
    @(posedge clk_2f); @(negedge clk_2f);
    // Word presented on the release edge goes to lane 0
    valid_in = 1'b1; data_in = 32'h3;
    reset = 1'b1;
    @(posedge clk_2f); @(negedge clk_2f);
    check("midrst_w3_lane0", 1, 32'h3, 0, 32'h0);
    data_in = 32'h4;
    @(posedge clk_2f); @(negedge clk_2f);
    check("midrst_w4_lane1", 1, 32'h3, 1, 32'h4);
    valid_in = 1'b0; data_in = '0;
    @(posedge clk_2f); @(negedge clk_2f);
    check("midrst_drain1", 0, 32'h0, 1, 32'h4);
    @(posedge clk_2f); @(negedge clk_2f);
    check("midrst_drain2", 0, 32'h0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
